clock_ctrl: RTL and testbench
=============================

// Module: clock_ctrl
// PURPOSE
//  Run/halt/single-step controller directly upstream of the divided clock block.
//  Drives that block's stop input and observes its generated clock output.
//  Lets the debug front-end free-run the machine clock, halt it, or release exactly N generated cycles.
//  Optionally counts generated cycles for the monitor.
// PARAMETERS
//  p_step_w   8   width of step-count request (max N = 2**p_step_w-1)
//  p_cycle_w  32  width of cycle counter (CLK_CTRL_CYCLE_CNT_EN only)
// PORTS
//  i_clk         in   1          system clock; the only clock
//  i_rst         in   1          reset, asynchronous, active-high
//  i_run         in   1          1-cycle pulse: free-run
//  i_halt        in   1          1-cycle pulse: stop at once
//  i_step        in   1          1-cycle pulse: release i_step_n generated cycles
//  i_step_n      in   p_step_w   step count, sampled with i_step; 0 treated as 1
//  i_gen         in   1          generated clock from the divided clock block, sampled on i_clk
//  o_stop        out  1          to the divided clock block's stop input; 1 = frozen
//  o_busy        out  1          1 in RUN or STEP
//  o_done        out  1          1-cycle pulse when a step burst completes
//  o_cycles      out  p_cycle_w  generated rising edges since reset
// BEHAVIOUR
//  Reset (async, i_rst=1):
//   - state HALT; o_stop=1, o_busy=0, o_done=0, o_cycles=0
//   - step counter=0, i_gen edge register=0
//  Edge detect: gen_q <= i_gen; rise = i_gen & ~gen_q. One rise per generated period.
//  FSM states HALT, RUN, STEP. Command priority: halt > run > step.
//  Commands are evaluated every cycle; the state updates on the next edge.
//  Transitions:
//   - HALT -i_run-> RUN; HALT -i_step-> STEP, loads rem = (i_step_n==0 ? 1 : i_step_n)
//   - RUN -i_halt-> HALT; i_step in RUN is ignored
//   - STEP -i_halt-> HALT: abort, no o_done
//   - STEP -i_run-> RUN: abort, no o_done
//   - STEP: on rise, rem <= rem-1; the rise with rem==1 -> HALT and o_done pulses next cycle
//   - Commands in HALT other than run/step are no-ops; i_halt in HALT is a no-op
//  o_stop / o_busy:
//   - o_stop registered: 0 in RUN/STEP, 1 in HALT
//   - o_stop rises the cycle after the final rise
//   - Divider p_divider >= 2 guarantees no extra tick before the freeze
//  Simultaneous events:
//   - halt+rise in STEP: the rise is counted (o_cycles increments), then abort
//   - rise on the entry cycle into STEP is not counted (rem loads, ignores rise)
//  Wrap: o_cycles wraps modulo 2**p_cycle_w, no flag.
//  Mid-operation reset: immediate return to the reset values above; a pending burst is lost.
// CONFIGURATION
//  CLK_CTRL_CYCLE_CNT_EN defined:
//   - o_cycles increments on every rise, in any state (a rise in HALT cannot occur in normal use)
//  CLK_CTRL_CYCLE_CNT_EN undefined:
//   - no counter flops; o_cycles tied to 0
//  No other behaviour changes with the macro.
// STRUCTURE
//  Package clock_ctrl_pkg: state enum t_cc_state {CC_HALT, CC_RUN, CC_STEP}; localparam CC_RESET_STOP = 1'b1.
//  Sub-module clock_ctrl_edge: i_gen sampler and rise detector (gen_q, o_rise).
//  Top holds the FSM, step counter and cycle counter.
// TESTING  (DUT wired to the divided clock block, p_divider=4)
//  1 reset mid-RUN -> o_stop=1, o_busy=0, o_cycles=0 within the same cycle as i_rst
//  2 i_step, i_step_n=3 from HALT:
//     - exactly 3 rises of i_gen, then o_stop=1
//     - o_done one pulse; o_cycles=3
//  3 i_step, i_step_n=0 -> exactly 1 rise, o_done pulses once
//  4 i_run, wait 10 rises, i_halt -> o_stop=1 next cycle, no further rises, o_done never pulses
//  5 i_step n=5, i_halt after 2 rises -> o_stop=1, o_done=0, o_cycles=2
//     then i_run+i_halt in the same cycle -> stays HALT
//  6 p_cycle_w=4, free-run 17 rises -> o_cycles=1 (wrap)
//     with the macro undefined -> o_cycles=0 throughout

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the run/halt/single-step clock controller.
// Holds the FSM state encoding, the reset level of the stop output and a
// small helper used to derive the busy indication from the state.
package clock_ctrl_pkg;

    // Controller state: frozen, free-running, or releasing a counted burst.
    typedef enum logic [1:0] {
        CC_HALT = 2'd0,
        CC_RUN  = 2'd1,
        CC_STEP = 2'd2
    } t_cc_state;

    // The generated clock is frozen out of reset.
    localparam logic CC_RESET_STOP = 1'b1;

    // Any state other than HALT lets the generated clock tick.
    function automatic logic cc_is_busy(input t_cc_state s);
        return (s != CC_HALT);
    endfunction

endpackage

// File: rtl/clock_ctrl_edge.sv
// Samples the generated clock on i_clk and flags its rising edges.
// Latency: o_rise is combinational from i_gen against a 1-cycle history register.
// No backpressure: one rise per generated period, never held or queued.
module clock_ctrl_edge
    import clock_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_gen,
    output logic o_rise
);

    logic r_gen_q;

    // Previous-cycle sample of the generated clock for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gen_q <= 1'b0;
        end else begin
            r_gen_q <= i_gen;
        end
    end

    assign o_rise = i_gen & ~r_gen_q;

endmodule

// File: rtl/clock_ctrl.sv
// Run/halt/single-step controller driving the divided clock block's stop input.
// Latency: commands act on the next i_clk edge; o_stop/o_done are registered (1 cycle).
// No backpressure: command pulses are consumed in the cycle they arrive.
// Optional feature macro: CLK_CTRL_CYCLE_CNT_EN (generated-cycle counter on o_cycles).
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int p_step_w  = 8,
    parameter int p_cycle_w = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_run,
    input  logic                 i_halt,
    input  logic                 i_step,
    input  logic [p_step_w-1:0]  i_step_n,
    input  logic                 i_gen,
    output logic                 o_stop,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [p_cycle_w-1:0] o_cycles
);

    localparam logic [p_step_w-1:0] lp_step_one = {{(p_step_w-1){1'b0}}, 1'b1};

    t_cc_state           r_state;
    t_cc_state           w_state_nxt;
    logic [p_step_w-1:0] r_rem;
    logic [p_step_w-1:0] w_rem_nxt;
    logic [p_step_w-1:0] w_step_load;
    logic                w_rise;
    logic                w_burst_end;
    logic                r_stop;
    logic                r_done;

    clock_ctrl_edge u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_gen  (i_gen),
        .o_rise (w_rise)
    );

    // A zero-length step request still releases one generated cycle.
    assign w_step_load = (i_step_n == '0) ? lp_step_one : i_step_n;

    // Next-state and remaining-count logic; halt outranks run, run outranks step.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_burst_end = 1'b0;
        case (r_state)
            CC_HALT: begin
                // Rises cannot reach the step counter here: the load wins.
                if (!i_halt) begin
                    if (i_run) begin
                        w_state_nxt = CC_RUN;
                    end else if (i_step) begin
                        w_state_nxt = CC_STEP;
                        w_rem_nxt   = w_step_load;
                    end
                end
            end
            CC_RUN: begin
                // Step requests while free-running are dropped.
                if (i_halt) begin
                    w_state_nxt = CC_HALT;
                end
            end
            CC_STEP: begin
                if (i_halt) begin
                    w_state_nxt = CC_HALT;
                    w_rem_nxt   = '0;
                end else if (i_run) begin
                    w_state_nxt = CC_RUN;
                    w_rem_nxt   = '0;
                end else if (w_rise) begin
                    w_rem_nxt = r_rem - lp_step_one;
                    if (r_rem == lp_step_one) begin
                        w_state_nxt = CC_HALT;
                        w_burst_end = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = CC_HALT;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // FSM state and remaining-cycle counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CC_HALT;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Registered stop and burst-complete pulse; both change on the edge after the final rise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stop <= CC_RESET_STOP;
            r_done <= 1'b0;
        end else begin
            r_stop <= (w_state_nxt == CC_HALT);
            r_done <= w_burst_end;
        end
    end

    assign o_stop = r_stop;
    assign o_done = r_done;
    assign o_busy = cc_is_busy(r_state);

`ifdef CLK_CTRL_CYCLE_CNT_EN
    localparam logic [p_cycle_w-1:0] lp_cyc_one = {{(p_cycle_w-1){1'b0}}, 1'b1};

    logic [p_cycle_w-1:0] r_cycles;

    // Free-running count of generated rising edges, wrapping silently.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycles <= '0;
        end else if (w_rise) begin
            r_cycles <= r_cycles + lp_cyc_one;
        end
    end

    assign o_cycles = r_cycles;
`else
    assign o_cycles = '0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench: clock_ctrl wired to a p_divider=4 divided clock model.
// Each command sequence pushes its expected outcome; a monitor pops it when o_stop rises.
// Expected cycle counts follow the CLK_CTRL_CYCLE_CNT_EN build setting.
`timescale 1ns/1ps
module tb_clock_ctrl;

    localparam int P_STEP_W = 8;
    localparam int P_CYC_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_run, i_halt, i_step;
    logic [P_STEP_W-1:0] i_step_n;
    logic                gen;
    logic                o_stop, o_busy, o_done;
    logic [P_CYC_W-1:0]  o_cycles;

    always #5 clk = ~clk;

    clock_ctrl #(.p_step_w(P_STEP_W), .p_cycle_w(P_CYC_W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_run    (i_run),
        .i_halt   (i_halt),
        .i_step   (i_step),
        .i_step_n (i_step_n),
        .i_gen    (gen),
        .o_stop   (o_stop),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_cycles (o_cycles)
    );

    // Divided clock block, divide-by-4, frozen while o_stop is high.
    logic [1:0] div_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= 2'd0;
        else if (!o_stop) div_cnt <= div_cnt + 2'd1;
    end
    assign gen = div_cnt[1];

    typedef struct {
        int         id;
        bit         done;
        int         rises;
        logic [3:0] cycles;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts generated rises and done pulses, scores each return to HALT.
    int   rises = 0;
    int   base_rises = 0;
    int   done_cnt = 0;
    logic prev_gen = 1'b0;
    logic prev_stop = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            prev_gen   = gen;
            base_rises = rises;
            done_cnt   = 0;
            prev_stop  = 1'b1;
        end else begin
            if (gen && !prev_gen) rises++;
            prev_gen = gen;
            if (o_done) done_cnt++;
            if (o_stop && !prev_stop) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_halt: got halt with empty queue, expected none (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("seq %0d: scoring halt", mon_e.id);
                    check("done_pulses", done_cnt, mon_e.done ? 1 : 0);
                    check("gen_rises", rises - base_rises, mon_e.rises);
                    check("cycles", o_cycles, mon_e.cycles);
                    check("busy_at_halt", o_busy, 0);
                end
                base_rises = rises;
                done_cnt   = 0;
            end
            prev_stop = o_stop;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic run, input logic halt, input logic step, input int n);
        i_run    = run;
        i_halt   = halt;
        i_step   = step;
        i_step_n = P_STEP_W'(n);
        tick();
        i_run    = 1'b0;
        i_halt   = 1'b0;
        i_step   = 1'b0;
        i_step_n = '0;
    endtask

    task automatic push(input int id, input bit done, input int r);
        exp_t e;
        exp_total += r;
        e.id    = id;
        e.done  = done;
        e.rises = r;
`ifdef CLK_CTRL_CYCLE_CNT_EN
        e.cycles = exp_total[3:0];
`else
        e.cycles = 4'd0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic wait_rises(input int base, input int k);
        int t = 0;
        while ((rises - base) < k && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) check("wait_rises_timeout", rises - base, k);
    endtask

    task automatic wait_stop();
        int t = 0;
        while (!o_stop && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) check("wait_stop_timeout", o_stop, 1);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        exp_total = 0;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int b;
        rst = 1'b1; i_run = 1'b0; i_halt = 1'b0; i_step = 1'b0; i_step_n = '0;
        repeat (2) tick();
        check("rst_stop", o_stop, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cycles", o_cycles, 0);
        rst = 1'b0;
        tick();

        // 1: asynchronous reset in the middle of a free run
        b = rises;
        pulse(1'b1, 1'b0, 1'b0, 0);
        check("run_busy", o_busy, 1);
        check("run_stop", o_stop, 0);
        wait_rises(b, 5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_stop", o_stop, 1);
        check("async_rst_busy", o_busy, 0);
        check("async_rst_cycles", o_cycles, 0);
        tick();
        exp_total = 0;
        rst = 1'b0;
        tick();

        // 2: three-cycle burst
        push(2, 1'b1, 3);
        pulse(1'b0, 1'b0, 1'b1, 3);
        check("step_busy", o_busy, 1);
        wait_stop();

        // 3: zero-length request behaves as one cycle
        push(3, 1'b1, 1);
        pulse(1'b0, 1'b0, 1'b1, 0);
        wait_stop();

        // 4: free run for ten rises, then halt
        push(4, 1'b0, 10);
        b = rises;
        pulse(1'b1, 1'b0, 1'b0, 0);
        wait_rises(b, 10);
        pulse(1'b0, 1'b1, 1'b0, 0);
        wait_stop();

        // 5: abort a 5-cycle burst; halt coincides with the second rise
        do_reset();
        push(5, 1'b0, 2);
        b = rises;
        pulse(1'b0, 1'b0, 1'b1, 5);
        wait_rises(b, 2);
        pulse(1'b0, 1'b1, 1'b0, 0);
        wait_stop();
        // run and halt together from HALT: halt wins, nothing moves
        b = rises;
        pulse(1'b1, 1'b1, 1'b0, 0);
        repeat (8) tick();
        check("runhalt_stop", o_stop, 1);
        check("runhalt_busy", o_busy, 0);
        check("runhalt_rises", rises - b, 0);

        // 6: seventeen rises on a 4-bit counter wrap to 1
        do_reset();
        push(6, 1'b0, 17);
        b = rises;
        pulse(1'b1, 1'b0, 1'b0, 0);
        wait_rises(b, 17);
        pulse(1'b0, 1'b1, 1'b0, 0);
        wait_stop();

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
